// File: rtl/axi4_arbiter_r_nm_if.sv
// Shared AR/R control bundle between the read arbiter and the fabric muxes.
// Latency: none, wires only.
// Backpressure: m_ARBLOCK tells the fabric to gate the owner's AR handshake.
interface axi4_arbiter_r_nm_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] s_ARVALID;
  logic [NUM_MASTERS-1:0] s_RREADY;
  logic                   m_ARREADY;
  logic                   m_RVALID;
  logic                   m_RLAST;
  logic [NUM_MASTERS-1:0] m_RGRNT;
  logic                   m_ARBLOCK;

  // Arbiter side: observes requests and downstream handshakes, drives grant/block.
  modport slave (
    input  s_ARVALID,
    input  s_RREADY,
    input  m_ARREADY,
    input  m_RVALID,
    input  m_RLAST,
    output m_RGRNT,
    output m_ARBLOCK
  );

  // Fabric side: drives requests and downstream handshakes, consumes grant/block.
  modport master (
    output s_ARVALID,
    output s_RREADY,
    output m_ARREADY,
    output m_RVALID,
    output m_RLAST,
    input  m_RGRNT,
    input  m_ARBLOCK
  );
endinterface

// File: rtl/axi4_arbiter_r_nm.sv
// N-master AXI4 read-channel arbiter, round-robin, bus held while reads are outstanding.
// Latency: grant 1 cycle after a request seen in IDLE; release->IDLE->next grant is 2 edges.
// Backpressure: m_ARBLOCK (combinational from flops) stalls owner ARs at the outstanding limit.
// Optional per-tenure AR quantum: define AXI4_ARBITER_R_QUANTUM_EN.
module axi4_arbiter_r_nm #(
  parameter int NUM_MASTERS     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int QUANTUM         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  axi4_arbiter_r_nm_if.slave      bus,
  output logic                    busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]       LAST_RST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] GRNT_ONE = NUM_MASTERS'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Round-robin pick: first requester strictly after 'last', wrapping modulo N.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_MASTERS-1:0] req,
    input logic [IDX_W-1:0]       last
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    int               cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(last) + k) % NUM_MASTERS;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
    return pick;
  endfunction

  // One-hot to index; the grant is one-hot by construction, so OR-ing indices is exact.
  function automatic logic [IDX_W-1:0] oh_to_idx(
    input logic [NUM_MASTERS-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grnt_q,  grnt_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [IDX_W-1:0]       last_q,  last_d;

  logic                   own_arvalid;
  logic                   own_rready;
  logic [IDX_W-1:0]       own_idx;
  logic                   cnt_at_max;
  logic                   q_at_max;
  logic                   arblock;
  logic                   ar_hs;
  logic                   r_done;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   release_bus;
  logic                   req_any;
  logic [IDX_W-1:0]       winner;

`ifdef AXI4_ARBITER_R_QUANTUM_EN
  localparam int QCNT_W = $clog2(QUANTUM + 1);
  localparam logic [QCNT_W-1:0] Q_MAX = QCNT_W'(QUANTUM);
  localparam logic [QCNT_W-1:0] Q_ONE = QCNT_W'(1);

  logic [QCNT_W-1:0] qcnt_q, qcnt_d;

  // Quantum exhausted: owner is blocked for the rest of its tenure.
  always_comb begin
    q_at_max = (qcnt_q == Q_MAX);
  end
`else
  logic unused_quantum;

  // Without the quantum the owner may hold the bus indefinitely.
  always_comb begin
    q_at_max = 1'b0;
  end
  assign unused_quantum = ^QUANTUM;
`endif

  // Owner-qualified views of the per-master handshakes (all zero while idle).
  always_comb begin
    own_arvalid = |(bus.s_ARVALID & grnt_q);
    own_rready  = |(bus.s_RREADY  & grnt_q);
    own_idx     = oh_to_idx(grnt_q);
    req_any     = |bus.s_ARVALID;
    winner      = rr_pick(bus.s_ARVALID, last_q);
  end

  // Block and transfer events; block comes straight from flops so it adds no latency.
  always_comb begin
    cnt_at_max = (cnt_q == CNT_MAX);
    arblock    = cnt_at_max | q_at_max;
    ar_hs      = own_arvalid & bus.m_ARREADY & ~arblock;
    r_done     = bus.m_RVALID & bus.m_RLAST & own_rready;
  end

  // Outstanding count: +1 per accepted AR, -1 per completed burst, floor at 0.
  always_comb begin
    cnt_nxt = cnt_q;
    if (ar_hs && !r_done) begin
      cnt_nxt = cnt_q + CNT_ONE;
    end else if (r_done && !ar_hs) begin
      // A stray RLAST with nothing outstanding must not wrap the counter.
      cnt_nxt = (cnt_q == '0) ? '0 : (cnt_q - CNT_ONE);
    end
  end

  // Hand the bus back once nothing is in flight and the owner has stopped asking
  // (or has used up its quantum).
  always_comb begin
    release_bus = (state_q == ST_LOCK) && (cnt_nxt == '0) &&
                  (!own_arvalid || q_at_max);
  end

  // Arbitration FSM next state: IDLE picks a winner, LOCK tracks the tenure.
  always_comb begin
    state_d = state_q;
    grnt_d  = grnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
    qcnt_d  = qcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_any) begin
          state_d = ST_LOCK;
          grnt_d  = GRNT_ONE << winner;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
          qcnt_d  = '0;
`endif
        end
      end
      ST_LOCK: begin
        cnt_d = cnt_nxt;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
        if (ar_hs) begin
          qcnt_d = qcnt_q + Q_ONE;
        end
`endif
        if (release_bus) begin
          state_d = ST_IDLE;
          grnt_d  = '0;
          cnt_d   = '0;
          last_d  = own_idx;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
          qcnt_d  = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grnt_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight and restores master-0 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grnt_q  <= '0;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
      qcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
      qcnt_q  <= qcnt_d;
`endif
    end
  end

  // Outputs are flops or logic of flops only.
  always_comb begin
    bus.m_RGRNT   = grnt_q;
    bus.m_ARBLOCK = arblock;
    busy          = (state_q == ST_LOCK);
  end

endmodule

// File: tb/tb_axi4_arbiter_r_nm.sv
// Bench for the N-master read arbiter: directed scenarios then randomized traffic.
// Each cycle the outputs are compared with a tenure-level reference model.
// Optional quantum scenario runs when AXI4_ARBITER_R_QUANTUM_EN is defined.
module tb_axi4_arbiter_r_nm;

  localparam int NM   = 4;
  localparam int MAXO = 4;
`ifdef AXI4_ARBITER_R_QUANTUM_EN
  localparam int QNT = 2;
  localparam bit QEN = 1'b1;
`else
  localparam int QNT = 8;
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  axi4_arbiter_r_nm_if #(.NUM_MASTERS(NM)) bus ();

  axi4_arbiter_r_nm #(
    .NUM_MASTERS    (NM),
    .MAX_OUTSTANDING(MAXO),
    .QUANTUM        (QNT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 when idle), outstanding bursts, last winner, ARs this tenure.
  int m_own;
  int m_cnt;
  int m_last;
  int m_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_cnt  = 0;
    m_last = NM - 1;
    m_q    = 0;
  endtask

  task automatic drive(input logic [NM-1:0] arv, input logic arr, input logic rv,
                       input logic rl, input logic [NM-1:0] rr);
    bus.s_ARVALID = arv;
    bus.m_ARREADY = arr;
    bus.m_RVALID  = rv;
    bus.m_RLAST   = rl;
    bus.s_RREADY  = rr;
  endtask

  // Compare outputs against the model, advance the model with the current inputs, clock.
  task automatic tick();
    logic [NM-1:0] eg;
    bit            eb;
    bit            hs;
    bit            dn;
    int            nc;
    int            w;
    eg = (m_own < 0) ? '0 : (NM'(1) << m_own);
    eb = (m_own >= 0) && ((m_cnt == MAXO) || (QEN && (m_q == QNT)));
    chk("grant",   32'(bus.m_RGRNT),   32'(eg));
    chk("busy",    32'(busy),          32'(m_own >= 0));
    chk("arblock", 32'(bus.m_ARBLOCK), 32'(eb));
    if (rst) begin
      model_reset();
    end else if (m_own < 0) begin
      w = -1;
      for (int k = 1; k <= NM; k++) begin
        if (w < 0 && bus.s_ARVALID[(m_last + k) % NM]) w = (m_last + k) % NM;
      end
      if (w >= 0) begin
        m_own = w;
        m_cnt = 0;
        m_q   = 0;
      end
    end else begin
      hs = bus.s_ARVALID[m_own] && bus.m_ARREADY && !eb;
      dn = bus.m_RVALID && bus.m_RLAST && bus.s_RREADY[m_own];
      nc = m_cnt + int'(hs) - int'(dn);
      if (nc < 0) nc = 0;
      if (nc == 0 && (!bus.s_ARVALID[m_own] || (QEN && m_q == QNT))) begin
        m_last = m_own;
        m_own  = -1;
        m_q    = 0;
      end else begin
        m_q = m_q + int'(hs);
      end
      m_cnt = nc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state
    chk("rst_grant",   32'(bus.m_RGRNT),   32'h0);
    chk("rst_busy",    32'(busy),          32'h0);
    chk("rst_arblock", 32'(bus.m_ARBLOCK), 32'h0);

    // Masters 0 and 2 request: 0 wins first, 2 follows after a one-cycle gap
    drive(4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000); tick();
    chk("t1_grant0", 32'(bus.m_RGRNT), 32'b0001);
    chk("t1_busy",   32'(busy),        32'h1);
    drive(4'b0101, 1'b1, 1'b0, 1'b0, 4'b0000); tick();
    drive(4'b0100, 1'b0, 1'b1, 1'b1, 4'b0001); tick();
    chk("t1_release", 32'(bus.m_RGRNT), 32'b0000);
    drive(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000); tick();
    chk("t1_grant2", 32'(bus.m_RGRNT), 32'b0100);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); tick(); tick();

    // Master 3 alone fills the outstanding window
    drive(4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000); tick();
    chk("t2_grant3", 32'(bus.m_RGRNT), 32'b1000);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_block_at_max", 32'(bus.m_ARBLOCK), 32'h1);
    drive(4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000); tick();
    chk("t2_unblock", 32'(bus.m_ARBLOCK), 32'h0);
    drive(4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000); tick();
    chk("t2_fifth_ar", 32'(bus.m_ARBLOCK), 32'h1);
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_still_busy", 32'(busy), 32'h1);
    tick();
    chk("t2_release", 32'(bus.m_RGRNT), 32'b0000);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); tick();

    // Round-robin wrap: last=3 favours 0, then last=0 favours 3
    drive(4'b1001, 1'b0, 1'b0, 1'b0, 4'b0000); tick();
    chk("t4_wrap_grant0", 32'(bus.m_RGRNT), 32'b0001);
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000); tick();
    drive(4'b1001, 1'b0, 1'b0, 1'b0, 4'b0000); tick();
    chk("t4_grant3", 32'(bus.m_RGRNT), 32'b1000);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); tick(); tick();

    // Simultaneous AR and burst completion keeps the count and the grant
    drive(4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000); tick(); tick(); tick();
    drive(4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010); tick();
    chk("t3_hold", 32'(bus.m_RGRNT), 32'b0010);
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010); tick();
    chk("t3_one_left", 32'(bus.m_RGRNT), 32'b0010);
    tick();
    chk("t3_release", 32'(bus.m_RGRNT), 32'b0000);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); tick();

    // Reset mid-tenure with three reads outstanding
    drive(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000); tick(); tick(); tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("t5_grant",   32'(bus.m_RGRNT),   32'h0);
    chk("t5_busy",    32'(busy),          32'h0);
    chk("t5_arblock", 32'(bus.m_ARBLOCK), 32'h0);
    drive(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000); tick();
    chk("t5_prio0", 32'(bus.m_RGRNT), 32'b0001);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); tick(); tick();

`ifdef AXI4_ARBITER_R_QUANTUM_EN
    // Quantum hands the bus over even while the owner keeps requesting
    rst = 1'b1; tick();
    rst = 1'b0;
    drive(4'b0011, 1'b1, 1'b0, 1'b0, 4'b0000); tick();
    chk("t6_grant0", 32'(bus.m_RGRNT), 32'b0001);
    tick(); tick();
    chk("t6_quantum_block", 32'(bus.m_ARBLOCK), 32'h1);
    drive(4'b0011, 1'b1, 1'b1, 1'b1, 4'b0001); tick();
    chk("t6_draining", 32'(busy), 32'h1);
    tick();
    chk("t6_release", 32'(bus.m_RGRNT), 32'b0000);
    drive(4'b0011, 1'b1, 1'b0, 1'b0, 4'b0000); tick();
    chk("t6_grant1", 32'(bus.m_RGRNT), 32'b0010);
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000); tick(); tick();
`endif

    // Randomized traffic, including stray RLAST and occasional reset
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(NM'($urandom & $urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0),
            NM'($urandom | $urandom));
      tick();
    end
    rst = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
